// File: rtl/filter_cap_pkg.sv
// Shared types for the filter capture buffer: FSM state encoding and default sample width.
package filter_cap_pkg;

    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/filter_cap_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset.
module filter_cap_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 1000,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/filter_capture_buffer.sv
// Captures a block of filter output samples after a warm-up skip, tracks the unsigned
// peak, then drains the block in order over valid/ready with full throughput.
module filter_capture_buffer
    import filter_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1000,
    parameter int SKIP   = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] peak
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(DEPTH - 1);
    localparam logic [SW-1:0]    SKIP_LAST = SW'((SKIP > 0) ? SKIP - 1 : 0);

    state_e            state_q;
    logic [SW-1:0]     skip_q;
    logic [CNT_W-1:0]  count_q, raddr_q, acc_q;
    logic [DATA_W-1:0] peak_q, rd_data_q, skid_q, ram_rdata;
    logic              rd_valid_q, skid_v_q, pend_q, done_q;
    logic [1:0]        occ_d;
    logic              pop_d, issue_d, we_d;

    // Reads are credited against the two output slots (rd_data + skid) so an
    // in-flight RAM word always has somewhere to land even under backpressure.
    always_comb begin
        pop_d   = rd_valid_q && rd_ready;
        occ_d   = {1'b0, rd_valid_q} + {1'b0, skid_v_q} + {1'b0, pend_q} - {1'b0, pop_d};
        issue_d = (state_q == ST_DRAIN) && !done_q && (raddr_q != DEPTH_C) && (occ_d < 2'd2);
        we_d    = (state_q == ST_CAPTURE);
    end

    filter_cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we_d),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (issue_d),
        .raddr_i (raddr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            count_q    <= '0;
            raddr_q    <= '0;
            acc_q      <= '0;
            peak_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pend_q <= issue_d;
            if (issue_d) raddr_q <= raddr_q + 1'b1;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        count_q <= '0;
                        peak_q  <= '0;
                        skip_q  <= '0;
                        raddr_q <= '0;
                        acc_q   <= '0;
                        state_q <= (SKIP > 0) ? ST_SKIP : ST_CAPTURE;
                    end
                end
                ST_SKIP: begin
                    skip_q <= skip_q + 1'b1;
                    if (skip_q == SKIP_LAST) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    count_q <= count_q + 1'b1;
                    if (data_in > peak_q) peak_q <= data_in;
                    if (count_q == LAST_C) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // done pulses while still in DRAIN so a start in that cycle is ignored
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (pop_d) begin
                        acc_q <= acc_q + 1'b1;
                        if (acc_q == LAST_C) done_q <= 1'b1;
                    end
                end
            endcase

            if (!rd_valid_q || pop_d) begin
                if (skid_v_q) begin
                    rd_data_q  <= skid_q;
                    rd_valid_q <= 1'b1;
                    skid_q     <= ram_rdata;
                    skid_v_q   <= pend_q;
                end else begin
                    if (pend_q) rd_data_q <= ram_rdata;
                    rd_valid_q <= pend_q;
                end
            end else if (pend_q) begin
                skid_q   <= ram_rdata;
                skid_v_q <= 1'b1;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign count    = count_q;
    assign peak     = peak_q;

endmodule

// File: tb/tb_filter_capture_buffer.sv
// Scoreboard bench: two instances (16/4 and 1000/0), expected samples queued at stimulus time.
module tb_filter_capture_buffer;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [NDUT];
    logic        start [NDUT];
    logic        rd_ready [NDUT];
    logic        rd_valid [NDUT];
    logic        busy [NDUT];
    logic        done [NDUT];
    logic [23:0] data_in [NDUT];
    logic [23:0] rd_data [NDUT];
    logic [23:0] peak [NDUT];
    logic [9:0]  count [NDUT];

    int          tests = 0;
    int          fails = 0;
    logic [23:0] sbq [NDUT][$];
    int          skip_left [NDUT];
    int          cap_left [NDUT];
    int          pops_n [NDUT];
    bit          idle_m [NDUT];
    bit          exp_done [NDUT];
    bit          idle_pend [NDUT];
    bit          stall_v [NDUT];
    logic [23:0] stall_d [NDUT];
    logic [23:0] peak_m [NDUT];

    function automatic int depth_of(input int g);
        return (g == 0) ? 16 : 1000;
    endfunction

    function automatic int skip_of(input int g);
        return (g == 0) ? 4 : 0;
    endfunction

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        filter_capture_buffer #(
            .DATA_W (24),
            .DEPTH  ((g == 0) ? 16 : 1000),
            .SKIP   ((g == 0) ? 4 : 0),
            .CNT_W  (10)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .start    (start[g]),
            .data_in  (data_in[g]),
            .rd_data  (rd_data[g]),
            .rd_valid (rd_valid[g]),
            .rd_ready (rd_ready[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .count    (count[g]),
            .peak     (peak[g])
        );

        // Monitor: a beat seen here completes on the following rising edge.
        always @(negedge clk) begin
            if (exp_done[g]) begin
                check("done_pulse", g, 32'(done[g]), 1);
                check("valid_after_last", g, 32'(rd_valid[g]), 0);
                exp_done[g]  = 0;
                idle_pend[g] = 1;
                idle_m[g]    = 1;
            end else begin
                if (done[g] !== 1'b0) check("spurious_done", g, 32'(done[g]), 0);
                if (idle_pend[g]) begin
                    check("idle_after_done", g, 32'(busy[g]), 0);
                    idle_pend[g] = 0;
                end
            end
            if (stall_v[g]) begin
                check("stall_valid", g, 32'(rd_valid[g]), 1);
                check("stall_data", g, 32'(rd_data[g]), 32'(stall_d[g]));
            end
            if (rd_valid[g] && rd_ready[g]) begin
                if (sbq[g].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat dut%0d: got data %0h expected no beat (scoreboard empty)", g, rd_data[g]);
                end else begin
                    check("rd_data", g, 32'(rd_data[g]), 32'(sbq[g].pop_front()));
                end
                pops_n[g]++;
                if (pops_n[g] == depth_of(g)) exp_done[g] = 1;
            end
            stall_v[g] = rd_valid[g] && !rd_ready[g];
            stall_d[g] = rd_data[g];
        end
    end

    // Drive one edge's inputs and advance the reference model for that edge.
    task automatic cyc(input int g, input bit st, input logic [23:0] d, input bit rdy, input bit r);
        for (int i = 0; i < NDUT; i++) start[i] = 1'b0;
        start[g]    = st;
        data_in[g]  = d;
        rd_ready[g] = rdy;
        rst[g]      = r;
        if (!r) begin
            if (skip_left[g] > 0) skip_left[g]--;
            else if (cap_left[g] > 0) begin
                sbq[g].push_back(d);
                if (d > peak_m[g]) peak_m[g] = d;
                cap_left[g]--;
            end
            if (st && idle_m[g]) begin
                idle_m[g]    = 0;
                skip_left[g] = skip_of(g);
                cap_left[g]  = depth_of(g);
                peak_m[g]    = '0;
                pops_n[g]    = 0;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            sbq[g].delete();
            idle_m[g]    = 1;
            skip_left[g] = 0;
            cap_left[g]  = 0;
            peak_m[g]    = '0;
            pops_n[g]    = 0;
            exp_done[g]  = 0;
            idle_pend[g] = 0;
            stall_v[g]   = 0;
        end
    endtask

    // mode: 0 edge index, 1 random, 2 peak pattern, 3 FIR output. rmode: 0 ready high, 1 random.
    task automatic run(input int g, input int mode, input int rmode, input int ign_k,
                       input bit ign_done, input int rst_pops, output int lat);
        int          k;
        int          j;
        int          k0;
        bit          st;
        bit          rdy;
        bit          ign_pend;
        logic [23:0] d;
        logic [23:0] x [5];
        k0       = 10;
        k        = 0;
        lat      = -1;
        ign_pend = 0;
        for (int i = 0; i < 5; i++) x[i] = '0;
        while (1) begin
            st = (k == k0) || (k == ign_k) || ign_pend;
            j  = k - k0 - skip_of(g) - 1;
            case (mode)
                0: d = k[23:0];
                1: d = 24'($urandom);
                2: d = (j < 0) ? 24'hFFFFFF : (j == 0) ? 24'h000010 : (j == 1) ? 24'hFFFFFE :
                       (j == 2) ? 24'h800000 : 24'h000001;
                default: begin
                    for (int i = 4; i > 0; i--) x[i] = x[i-1];
                    x[0] = 24'($urandom);
                    d = 24'(x[0] + 2 * x[1] + 3 * x[2] + 2 * x[3] + x[4]);
                end
            endcase
            rdy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
            cyc(g, st, d, rdy, 1'b0);
            ign_pend = 0;
            if (k == k0) begin
                check("start_clear_count", g, 32'(count[g]), 0);
                check("start_clear_peak", g, 32'(peak[g]), 0);
            end
            if (done[g] && lat < 0) begin
                lat = k - k0;
                if (ign_done) ign_pend = 1;
            end
            if (rst_pops >= 0 && k > k0 && pops_n[g] == rst_pops) begin
                cyc(g, 1'b0, d, 1'b0, 1'b1);
                return;
            end
            k++;
            if (lat >= 0 && k > k0 + lat + 4) break;
            if (k > 4000) begin
                tests++;
                fails++;
                $display("FAIL timeout dut%0d: got no done expected done within 4000 cycles", g);
                break;
            end
        end
    endtask

    task automatic block_end(input string nm, input int g);
        check({nm, "_count"}, g, 32'(count[g]), 32'(depth_of(g)));
        check({nm, "_peak"}, g, 32'(peak[g]), 32'(peak_m[g]));
        check({nm, "_leftover"}, g, 32'(sbq[g].size()), 0);
        check({nm, "_busy"}, g, 32'(busy[g]), 0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; data_in[i] = '0; rd_ready[i] = 1'b0;
            idle_m[i] = 1; exp_done[i] = 0; idle_pend[i] = 0; stall_v[i] = 0;
            skip_left[i] = 0; cap_left[i] = 0; pops_n[i] = 0; peak_m[i] = '0; stall_d[i] = '0;
        end
        cyc(0, 1'b0, '0, 1'b0, 1'b1);
        cyc(1, 1'b0, '0, 1'b0, 1'b1);
        for (int g = 0; g < NDUT; g++) begin
            check("rst_valid", g, 32'(rd_valid[g]), 0);
            check("rst_data", g, 32'(rd_data[g]), 0);
            check("rst_busy", g, 32'(busy[g]), 0);
            check("rst_done", g, 32'(done[g]), 0);
            check("rst_count", g, 32'(count[g]), 0);
            check("rst_peak", g, 32'(peak[g]), 0);
            rst[g] = 1'b0;
        end

        // Basic block: edge-index data, ready high, window 15..30
        run(0, 0, 0, -1, 1'b0, -1, lat);
        check("basic_latency", 0, 32'(lat), 38);
        check("basic_peak_abs", 0, 32'(peak[0]), 30);
        block_end("basic", 0);

        // Same data under random backpressure
        run(0, 0, 1, -1, 1'b0, -1, lat);
        block_end("bp", 0);

        // start mid-capture and in the done cycle must be ignored
        run(0, 1, 0, 22, 1'b1, -1, lat);
        check("ign_latency", 0, 32'(lat), 38);
        block_end("ign", 0);
        run(0, 1, 1, -1, 1'b0, -1, lat);
        block_end("fresh", 0);

        // Reset after 5 accepts in DRAIN
        run(0, 0, 0, -1, 1'b0, 5, lat);
        check("rstmid_valid", 0, 32'(rd_valid[0]), 0);
        check("rstmid_busy", 0, 32'(busy[0]), 0);
        check("rstmid_count", 0, 32'(count[0]), 0);
        check("rstmid_peak", 0, 32'(peak[0]), 0);
        for (int i = 0; i < 6; i++) cyc(0, 1'b0, '0, 1'b1, 1'b0);
        run(0, 1, 1, -1, 1'b0, -1, lat);
        block_end("after_rst", 0);

        // Peak pattern, SKIP=0; the uncaptured start-edge sample is 0xFFFFFF
        run(1, 2, 0, -1, 1'b0, -1, lat);
        check("peak_latency", 1, 32'(lat), 2002);
        check("peak_abs", 1, 32'(peak[1]), 32'h00FFFFFE);
        block_end("peak", 1);

        // Full-depth FIR output stream with random backpressure
        run(1, 3, 1, -1, 1'b0, -1, lat);
        block_end("fir", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_capture_buffer.md
Name: filter_capture_buffer

Overview:
- Receiving end of the filter output stream: takes the 24-bit per-cycle result from the FIR filter, discards a programmable warm-up run, captures a block of samples into on-chip RAM, then drains them in order over a valid/ready interface.
- Sits between the filter output and the host/readback path.
- Replaces file-based capture for on-silicon checking.
- Also records the unsigned peak of the captured block.

Parameters:
- DATA_W, 24, sample width (matches filter output).
- DEPTH, 1000, samples captured per block (>=2).
- SKIP, 8, samples discarded after start, before capture (0 allowed).
- CNT_W, $clog2(DEPTH+1), width of counters and count output.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle arm pulse; honoured only in IDLE.
- data_in  in  DATA_W  filter output sample; one valid sample every clk.
- rd_data  out  DATA_W  drained sample.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  downstream accepts rd_data when rd_valid && rd_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last sample is accepted.
- count  out  CNT_W  samples captured so far in the current block.
- peak  out  DATA_W  unsigned maximum of captured samples.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; rd_valid=0, rd_data=0, busy=0, done=0, count=0, peak=0; pointers cleared. RAM contents are don't-care. Reset mid-capture or mid-drain aborts immediately and emits no done.
- IDLE:
  - start=1 -> SKIP if SKIP>0, else CAPTURE.
  - Clears count and peak on the same edge.
- SKIP:
  - Counts SKIP cycles; data_in is ignored.
  - After the SKIP-th sample -> CAPTURE.
- CAPTURE:
  - Writes data_in to RAM[count] every cycle and increments count.
  - peak <= max(peak, data_in), unsigned compare; count and peak are registered.
  - The sample taken on the edge that enters CAPTURE is not captured. The first captured sample is the one present on the first edge in CAPTURE.
  - When count reaches DEPTH -> DRAIN.
- DRAIN:
  - Synchronous-read RAM (1-cycle read latency).
  - rd_valid first asserts 2 cycles after entering DRAIN, with rd_data=RAM[0].
  - Samples are presented in capture order, address 0..DEPTH-1.
  - While rd_valid && !rd_ready, rd_data and rd_valid hold stable.
  - rd_ready may toggle arbitrarily; a prefetch/skid register is required for full throughput.
  - Zero bubbles when rd_ready is held high: one sample per cycle after the initial latency.
  - After sample DEPTH-1 is accepted: rd_valid=0 the next cycle, done=1 for exactly one cycle, then -> IDLE.
  - count and peak hold their final values until the next start.
- start outside IDLE is ignored, including start in the same cycle done pulses.
- rd_ready while rd_valid=0 has no effect.
- data_in is unsigned DATA_W bits and is not modified.
- No overflow condition exists: capture stops at DEPTH.

Decomposition:
- Package filter_cap_pkg:
  - state enum {IDLE, SKIP, CAPTURE, DRAIN}.
  - DATA_W default constant.
- One sub-module: filter_cap_ram.
  - Simple dual-port RAM, DEPTH x DATA_W.
  - One write port, one synchronous read port, no reset.
- The top level holds the FSM, counters, peak register and output skid register.

Test Plan:
- Basic block: DEPTH=16, SKIP=4, data_in = cycle index (0,1,2,...), start at cycle 10, rd_ready=1. Expected: the capture window begins with 15 and rd_data = 15..30 in order, 16 consecutive valid beats, done once, peak=30, count=16.
- Backpressure: same stimulus, rd_ready = random 50%. Expected: identical accepted sequence 15..30; rd_data stable whenever rd_valid && !rd_ready; exactly 16 handshakes.
- Peak: data_in pattern 0x000010, 0xFFFFFE, 0x800000, then 0x000001 repeated, SKIP=0. Expected: peak=0xFFFFFE (unsigned); values drain unchanged.
- Start ignored: pulse start during CAPTURE and during the done cycle. Expected: no restart, count unaffected; a new start in IDLE then captures a fresh block and clears peak.
- Reset mid-operation: assert rst for 1 cycle midway through DRAIN after 5 accepts. Expected: next cycle rd_valid=0, busy=0, count=0, peak=0, no done; a subsequent start works normally.
- SKIP=0 / DEPTH=1000 default run: 1000 samples from a filter model. Expected: drained stream equals the filter model output offset by one cycle from start; done after the 1000th accept.
